// File: rtl/sap_pkg.sv
// Shared constants, RAM controller states and parity helper for the SAP panel blocks.
package sap_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int RAM_DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ram_state_t;

    // Even parity bit: XOR of all data bits, so word plus parity has an even count of ones.
    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/falling_edge_detect.sv
// Registered-history falling-edge detector for active-low panel push-buttons.
module falling_edge_detect (
    input  logic CLOCK,
    input  logic _RESET,
    input  logic SIG,
    output logic FALL
);

    logic prev_reg;

    // History resets high so a button already held low at reset release counts as a press.
    always_ff @(posedge CLOCK) begin
        if (!_RESET) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= SIG;
        end
    end

    assign FALL = prev_reg & ~SIG;

endmodule

// File: rtl/random_access_memory.sv
// 16x8 program/data RAM fed by the MAR, with post-reset clear sweep and W-bus output.
// Optional stored even parity per word when RAM_PARITY_EN is defined.
module random_access_memory
    import sap_pkg::ram_state_t;
    import sap_pkg::IDLE;
    import sap_pkg::CLEAR;
    import sap_pkg::even_parity;
#(
    parameter int ADDR_W         = sap_pkg::ADDR_W,
    parameter int DATA_W         = sap_pkg::DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              CLOCK,
    input  logic              _RESET,
    input  logic [ADDR_W-1:0] RAM_ADDR,
    input  logic [DATA_W-1:0] RAM_DATA_PROG,
    input  logic              _RAM_PROG,
    input  logic              _RAM_WE_PROG,
    input  logic              _EN_RAM_OUT,
    output logic [DATA_W-1:0] RAM_BUS,
    output logic              BUSY,
    output logic              WR_DONE,
    output logic              PARITY_ERR
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    logic [WORD_W-1:0] mem_reg [DEPTH];

    ram_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic [DATA_W-1:0] data_q_reg;
    logic              wr_done_reg;
    logic              we_fall;
    logic              wr_commit;
    logic              clr_we;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic              bus_en;

    falling_edge_detect u_we_edge (
        .CLOCK  (CLOCK),
        ._RESET (_RESET),
        .SIG    (_RAM_WE_PROG),
        .FALL   (we_fall)
    );

    always_ff @(posedge CLOCK) begin
        if (!_RESET) begin
            state_reg <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        clr_we     = 1'b0;
        case (state_reg)
            CLEAR: begin
                clr_we   = 1'b1;
                cnt_next = cnt_reg + ADDR_W'(1);
                if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
            IDLE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Edges seen during the sweep or outside program mode are dropped, not queued.
    assign wr_commit = we_fall && !_RAM_PROG && (state_reg == IDLE);

`ifdef RAM_PARITY_EN
    assign wr_word = {even_parity(RAM_DATA_PROG), RAM_DATA_PROG};
`else
    assign wr_word = RAM_DATA_PROG;
`endif

    // Storage is left alone while reset is held; the sweep does the zeroing afterwards.
    always_ff @(posedge CLOCK) begin
        if (_RESET) begin
            if (clr_we) begin
                mem_reg[cnt_reg] <= '0;
            end else if (wr_commit) begin
                mem_reg[RAM_ADDR] <= wr_word;
            end
        end
    end

    assign rd_word = mem_reg[RAM_ADDR];

    always_ff @(posedge CLOCK) begin
        if (!_RESET) begin
            data_q_reg  <= '0;
            wr_done_reg <= 1'b0;
        end else begin
            wr_done_reg <= wr_commit;
            data_q_reg  <= (state_reg == IDLE) ? rd_word[DATA_W-1:0] : '0;
        end
    end

    assign BUSY    = (state_reg == CLEAR);
    assign WR_DONE = wr_done_reg;
    assign bus_en  = !_EN_RAM_OUT && !BUSY;
    assign RAM_BUS = bus_en ? data_q_reg : '0;

`ifdef RAM_PARITY_EN
    logic parity_err_reg;

    always_ff @(posedge CLOCK) begin
        if (!_RESET) begin
            parity_err_reg <= 1'b0;
        end else if (state_reg == IDLE) begin
            parity_err_reg <= rd_word[DATA_W] ^ even_parity(rd_word[DATA_W-1:0]);
        end else begin
            parity_err_reg <= 1'b0;
        end
    end

    assign PARITY_ERR = bus_en & parity_err_reg;
`else
    assign PARITY_ERR = 1'b0;
`endif

endmodule
